// File: rtl/v2k_reg_arbiter.sv
// rtl/v2k_reg_arbiter.sv - round-robin arbiter feeding one shared holding register
module v2k_reg_arbiter #(
  parameter  int WIDTH = 16,
  parameter  int NREQ  = 4,
  localparam int SRCW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*(WIDTH+1)-1:0] req_data,
  output logic [NREQ-1:0]         gnt,
  output logic                    out_valid,
  output logic [WIDTH:0]          out_data,
  output logic [SRCW-1:0]         out_src,
  input  logic                    out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [SRCW-1:0]   ptr;
  logic [SRCW-1:0]   winner;
  logic [SRCW:0]     idx;
  logic              found;
  logic              cap;

  // Search starts at ptr and wraps; idx is one bit wider so the wrap compare cannot overflow.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (SRCW+1)'(k);
      if (idx >= (SRCW+1)'(NREQ))
        idx = idx - (SRCW+1)'(NREQ);
      if (!found && req[idx[SRCW-1:0]]) begin
        found  = 1'b1;
        winner = idx[SRCW-1:0];
      end
    end
  end

  assign cap = (|req) && (state == EMPTY || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        out_data <= req_data[winner*(WIDTH+1) +: (WIDTH+1)];
        out_src  <= winner;
        ptr      <= (winner == SRCW'(NREQ-1)) ? '0 : winner + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (cap)
      state_nxt = FULL;
    else if (state == FULL && out_ready)
      state_nxt = EMPTY;
  end

  // gnt follows out_ready combinationally so a draining FULL slot can refill in the same cycle.
  always_comb begin
    out_valid = (state == FULL);
    gnt       = '0;
    if (cap && !rst)
      gnt[winner] = 1'b1;
  end

endmodule

// File: tb/tb_v2k_reg_arbiter.sv
// tb/tb_v2k_reg_arbiter.sv - scoreboard bench for the round-robin register arbiter
module tb_v2k_reg_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int SRCW  = $clog2(NREQ);

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NREQ-1:0]           req = '0;
  logic [NREQ*(WIDTH+1)-1:0] req_data = '0;
  logic [NREQ-1:0]           gnt;
  logic                      out_valid;
  logic [WIDTH:0]            out_data;
  logic [SRCW-1:0]           out_src;
  logic                      out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [SRCW+WIDTH:0] sb_q[$];
  int                  m_ptr = 0;
  logic                m_full = 1'b0;

  v2k_reg_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++)
      req_data[i*(WIDTH+1) +: (WIDTH+1)] = (WIDTH+1)'($urandom);
  endtask

  // Reference model sampled mid-cycle: checks gnt/out_valid, pops on transfer, pushes on capture.
  always @(negedge clk) begin
    automatic logic           m_cap;
    automatic int             w;
    automatic logic [NREQ-1:0] exp_gnt;
    automatic logic [SRCW+WIDTH:0] head;
    if (rst) begin
      sb_q.delete();
      m_ptr  = 0;
      m_full = 1'b0;
    end else begin
      check_eq("mon_valid", 32'(out_valid), 32'(m_full));
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("mon_sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          head = sb_q[0];
          check_eq("mon_data", 32'(out_data), 32'(head[WIDTH:0]));
          check_eq("mon_src", 32'(out_src), 32'(head[SRCW+WIDTH:WIDTH+1]));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      m_cap   = (|req) && (!m_full || out_ready);
      exp_gnt = '0;
      w       = -1;
      if (m_cap) begin
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        exp_gnt[w] = 1'b1;
        sb_q.push_back({SRCW'(w), req_data[w*(WIDTH+1) +: (WIDTH+1)]});
        m_ptr  = (w + 1) % NREQ;
        m_full = 1'b1;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
      check_eq("mon_gnt", 32'(gnt), 32'(exp_gnt));
    end
  end

  initial begin
    // 1: reset values, gnt suppressed while rst even with requests pending
    req = 4'b1111;
    rand_data();
    #12;
    check_eq("t1_valid", 32'(out_valid), 32'd0);
    check_eq("t1_data", 32'(out_data), 32'd0);
    check_eq("t1_gnt", 32'(gnt), 32'd0);
    req = '0;
    step();
    rst = 1'b0;
    repeat (3) step();
    check_eq("t1_idle", 32'(out_valid), 32'd0);

    // 2: single request, one-cycle latency
    req = 4'b0001;
    req_data[0 +: WIDTH+1] = 17'h1ABCD;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t2_gnt", 32'(gnt), 32'b0001);
    step();
    req = '0;
    @(negedge clk);
    check_eq("t2_valid", 32'(out_valid), 32'd1);
    check_eq("t2_data", 32'(out_data), 32'h1ABCD);
    check_eq("t2_src", 32'(out_src), 32'd0);
    step();

    // 3: from ptr=0, all requesting, back-to-back round robin
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      @(negedge clk);
      check_eq("t3_gnt", 32'(gnt), 32'(1 << (i % 4)));
      if (i > 0) check_eq("t3_valid", 32'(out_valid), 32'd1);
      step();
    end

    // 4: stalled FULL blocks grants and holds data
    req = 4'b0010;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t4_stall_gnt", 32'(gnt), 32'd0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_release_gnt", 32'(gnt), 32'b0010);
    step();

    // 5: ptr=2, req 3 and 0 -> 3 first, then wrap to 0
    req = 4'b1001;
    rand_data();
    @(negedge clk);
    check_eq("t5_gnt3", 32'(gnt), 32'b1000);
    step();
    req = 4'b0001;
    rand_data();
    @(negedge clk);
    check_eq("t5_gnt0", 32'(gnt), 32'b0001);
    step();
    req = '0;
    @(negedge clk);
    check_eq("t5_src", 32'(out_src), 32'd0);
    step();

    // 6: async reset mid-FULL, then restart from ptr=0
    req = 4'b0100;
    out_ready = 1'b0;
    rand_data();
    step();
    req = '0;
    #3;
    rst = 1'b1;
    #1;
    check_eq("t6_async_valid", 32'(out_valid), 32'd0);
    check_eq("t6_async_gnt", 32'(gnt), 32'd0);
    step();
    rst = 1'b0;
    req = 4'b0110;
    out_ready = 1'b1;
    rand_data();
    @(negedge clk);
    check_eq("t6_first_gnt", 32'(gnt), 32'b0010);
    step();
    req = '0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
